// File: rtl/pll_rst_seq.sv
// Reset/lock sequencer for the rPLL: pulses PLL reset, filters LOCK, releases system reset, retries on timeout.
// Optional loss-of-lock event counter output lol_cnt_o enabled by defining PLL_RST_SEQ_LOL_CNT_EN.
module pll_rst_seq #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned FILT_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o
`ifdef PLL_RST_SEQ_LOL_CNT_EN
  ,
  output logic [7:0] lol_cnt_o
`endif
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > FILT_CYCLES) ? RST_CYCLES : FILT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    ST_PRST,
    ST_WAIT,
    ST_FILT,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic [1:0]         sync_q, sync_d;
  logic               lock_s;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               locked_q, locked_d;
  logic               fail_q, fail_d;

  assign lock_s = sync_q[1];

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    sync_d  = {sync_q[0], pll_lock_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    unique case (state_q)
      ST_PRST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (lock_s) begin
          state_d = ST_FILT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_PRST;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_FILT: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s) state_d = ST_WAIT;
        else if (cnt_q == CNT_W'(FILT_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_PRST;
          retry_d = 4'd0;
        end
      end
      ST_FAIL: ;
      default: state_d = ST_PRST;
    endcase

    if (restart_i) begin
      state_d = ST_PRST;
      retry_d = 4'd0;
    end

    // A restart while already in PRST must still re-run the full pulse.
    if (state_d != state_q || restart_i) cnt_d = '0;

    // Outputs are decoded from the next state so the registers line up with state_q.
    pll_rst_d = (state_d == ST_PRST) || (state_d == ST_FAIL);
    sys_rst_d = (state_d != ST_RUN);
    locked_d  = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PRST;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      sync_q    <= 2'b00;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      sync_q    <= sync_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign locked_o    = locked_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

`ifdef PLL_RST_SEQ_LOL_CNT_EN
  logic [7:0] lol_q, lol_d;

  // Restart outranks lock loss, so a restart out of RUN is not counted.
  always_comb begin
    lol_d = lol_q;
    if (state_q == ST_RUN && !lock_s && !restart_i && lol_q != 8'hFF) lol_d = lol_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) lol_q <= 8'd0;
    else     lol_q <= lol_d;
  end

  assign lol_cnt_o = lol_q;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: expectations are queued with the stimulus and popped when outputs are measured.
module tb_pll_rst_seq;

  localparam int RST_C  = 4;
  localparam int FILT_C = 8;
  localparam int TO_C   = 20;
  localparam int MAX_R  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock_i;
  logic       restart_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       locked_o;
  logic       fail_o;
  logic [3:0] retry_cnt_o;
`ifdef PLL_RST_SEQ_LOL_CNT_EN
  logic [7:0] lol_cnt_o;
`endif

  pll_rst_seq #(
    .RST_CYCLES    (RST_C),
    .FILT_CYCLES   (FILT_C),
    .TIMEOUT_CYCLES(TO_C),
    .MAX_RETRY     (MAX_R)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock_i (pll_lock_i),
    .restart_i  (restart_i),
    .pll_rst_o  (pll_rst_o),
    .sys_rst_o  (sys_rst_o),
    .locked_o   (locked_o),
    .fail_o     (fail_o),
    .retry_cnt_o(retry_cnt_o)
`ifdef PLL_RST_SEQ_LOL_CNT_EN
    ,
    .lol_cnt_o  (lol_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {S_PLL_RST, S_SYS_RST, S_LOCKED, S_FAIL} sig_e;
  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_val(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic observe(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sig_val(input sig_e s);
    case (s)
      S_PLL_RST: return int'(pll_rst_o);
      S_SYS_RST: return int'(sys_rst_o);
      S_LOCKED:  return int'(locked_o);
      default:   return int'(fail_o);
    endcase
  endfunction

  // Counts samples (one per cycle, starting now) while the signal holds lvl; bounded by max_n.
  task automatic count_while(input sig_e s, input int lvl, input int max_n, output int n);
    n = 0;
    while (sig_val(s) == lvl && n < max_n) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
  endtask

  int n;
  int low_seen;

  initial begin
    rst        = 1'b1;
    pll_lock_i = 1'b0;
    restart_i  = 1'b0;
    repeat (3) tick();

    // Reset values
    expect_val("rst_pll_rst", 1);  observe(int'(pll_rst_o));
    expect_val("rst_sys_rst", 1);  observe(int'(sys_rst_o));
    expect_val("rst_locked", 0);   observe(int'(locked_o));
    expect_val("rst_fail", 0);     observe(int'(fail_o));
    expect_val("rst_retry", 0);    observe(int'(retry_cnt_o));

    // Nominal lock
    rst = 1'b0;
    expect_val("nom_prst_width", RST_C);
    count_while(S_PLL_RST, 1, 100, n);
    observe(n);
    repeat (3) tick();
    pll_lock_i = 1'b1;
    expect_val("nom_release_lat", 2 + 1 + FILT_C);
    count_while(S_SYS_RST, 1, 200, n);
    observe(n);
    expect_val("nom_locked", 1);   observe(int'(locked_o));
    expect_val("nom_retry", 0);    observe(int'(retry_cnt_o));
    expect_val("nom_pll_rst", 0);  observe(int'(pll_rst_o));

    // Loss of lock in RUN for 3 cycles
    pll_lock_i = 1'b0;
    expect_val("lol_sys_rise", 3);
    count_while(S_SYS_RST, 0, 50, n);
    observe(n);
    pll_lock_i = 1'b1;
    expect_val("lol_prst_width", RST_C);
    count_while(S_PLL_RST, 1, 50, n);
    observe(n);
    expect_val("lol_relock", 1 + FILT_C);
    count_while(S_LOCKED, 0, 200, n);
    observe(n);
    expect_val("lol_retry", 0);    observe(int'(retry_cnt_o));
`ifdef PLL_RST_SEQ_LOL_CNT_EN
    expect_val("lol_cnt", 1);      observe(int'(lol_cnt_o));
`endif

    // Filter glitch: lock high 5, low 1, high again
    pll_lock_i = 1'b0;
    pulse_restart();
    expect_val("glt_prst_width", RST_C);
    count_while(S_PLL_RST, 1, 50, n);
    observe(n);
    pll_lock_i = 1'b1;
    low_seen   = 0;
    repeat (5) begin
      tick();
      if (!sys_rst_o) low_seen++;
    end
    pll_lock_i = 1'b0;
    tick();
    if (!sys_rst_o) low_seen++;
    pll_lock_i = 1'b1;
    expect_val("glt_release_lat", 2 + 1 + FILT_C);
    count_while(S_SYS_RST, 1, 200, n);
    observe(n);
    expect_val("glt_no_early", 0); observe(low_seen);

    // Timeout retry: two silent attempts, lock on the third
    pll_lock_i = 1'b0;
    pulse_restart();
    for (int a = 0; a < 3; a++) begin
      expect_val($sformatf("rty_width%0d", a), RST_C);
      count_while(S_PLL_RST, 1, 50, n);
      observe(n);
      if (a < 2) begin
        expect_val($sformatf("rty_gap%0d", a), TO_C);
        count_while(S_PLL_RST, 0, 100, n);
        observe(n);
      end
    end
    pll_lock_i = 1'b1;
    expect_val("rty_release_lat", 2 + 1 + FILT_C);
    count_while(S_SYS_RST, 1, 200, n);
    observe(n);
    expect_val("rty_locked", 1);   observe(int'(locked_o));
    expect_val("rty_retry", MAX_R); observe(int'(retry_cnt_o));

    // Fail: lock never asserts
    pll_lock_i = 1'b0;
    restart_i  = 1'b1;
    expect_val("fail_latency", 1 + (MAX_R + 1) * (RST_C + TO_C));
    tick();
    restart_i = 1'b0;
    count_while(S_FAIL, 0, 500, n);
    observe(n + 1);
    expect_val("fail_pll_rst", 1); observe(int'(pll_rst_o));
    expect_val("fail_sys_rst", 1); observe(int'(sys_rst_o));
    expect_val("fail_retry", MAX_R); observe(int'(retry_cnt_o));
    expect_val("fail_sticky", 30);
    count_while(S_FAIL, 1, 30, n);
    observe(n);
    pulse_restart();
    expect_val("rs_fail_clr", 0);  observe(int'(fail_o));
    expect_val("rs_retry_clr", 0); observe(int'(retry_cnt_o));
    expect_val("rs_prst_width", RST_C);
    count_while(S_PLL_RST, 1, 50, n);
    observe(n);

    // Reset in FILT cycle 5
    pll_lock_i = 1'b1;
    repeat (7) tick();
    expect_val("mid_in_filt", 1);
    observe(int'(sys_rst_o && !pll_rst_o && !locked_o));
    rst = 1'b1;
    tick();
    expect_val("mid_rst_pll", 1);  observe(int'(pll_rst_o));
    expect_val("mid_rst_sys", 1);  observe(int'(sys_rst_o));
    expect_val("mid_rst_lock", 0); observe(int'(locked_o));
    expect_val("mid_rst_retry", 0); observe(int'(retry_cnt_o));
    rst = 1'b0;
    expect_val("mid_prst_width", RST_C);
    count_while(S_PLL_RST, 1, 50, n);
    observe(n);
    expect_val("mid_release_lat", 1 + FILT_C);
    count_while(S_SYS_RST, 1, 200, n);
    observe(n);
`ifdef PLL_RST_SEQ_LOL_CNT_EN
    expect_val("mid_lol_cnt_rst", 0); observe(int'(lol_cnt_o));
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset and lock sequencer for the on-chip rPLL. Runs on the free-running crystal clock (27 MHz) that feeds the PLL.
- Pulses the PLL RESET and waits for LOCK. It then filters LOCK for stability before releasing the system reset request.
- Retries on lock timeout, re-sequences on loss of lock, and flags a permanent failure after a bounded number of retries.
- Sits between the PLL wrapper and the SoC reset tree. sys_rst_o is synchronized into the PLL clock domain by the consumer.

Parameters:
- RST_CYCLES, 16: cycles pll_rst_o is held high per attempt (≥1).
- FILT_CYCLES, 1024: consecutive cycles of synchronized lock required before release (≥1).
- TIMEOUT_CYCLES, 65535: cycles allowed in WAIT_LOCK before a retry (≥1).
- MAX_RETRY, 3: retries after the first attempt before FAIL (0..15).

Ports:
- clk  in  1  crystal reference clock, same net as the PLL clkin.
- rst  in  1  synchronous, active-high reset.
- pll_lock_i  in  1  raw PLL LOCK; asynchronous to clk.
- restart_i  in  1  single-cycle request to re-run the full sequence.
- pll_rst_o  out  1  PLL RESET drive.
- sys_rst_o  out  1  system reset request; high = hold SoC in reset.
- locked_o  out  1  high only in RUN.
- fail_o  out  1  sticky; high in FAIL.
- retry_cnt_o  out  4  retries consumed in the current sequence.

Behaviour:
- Lock input: two-flop synchronizer on pll_lock_i gives lock_s, with 2 cycles of latency. All decisions use lock_s only.
- Reset values while rst is high:
  - pll_rst_o=1, sys_rst_o=1, locked_o=0, fail_o=0, retry_cnt_o=0.
  - State = PRST, counter=0, synchronizer flops=0.
- All outputs are registered and decoded from state.
- A single shared counter, cnt, is cleared on every state entry. Its width is $clog2 of the largest of the three cycle parameters, plus 1.
- States:
  - PRST:
    - pll_rst_o=1, sys_rst_o=1.
    - After RST_CYCLES cycles in PRST, go to WAIT.
  - WAIT:
    - pll_rst_o=0, sys_rst_o=1.
    - If lock_s=1, go to FILT.
    - Else, if cnt reaches TIMEOUT_CYCLES-1:
      - if retry_cnt < MAX_RETRY: retry_cnt+=1 and go to PRST;
      - otherwise go to FAIL.
  - FILT:
    - sys_rst_o=1.
    - If lock_s=0, go to WAIT. The timeout counter restarts; retry_cnt is unchanged.
    - If lock_s has been 1 for FILT_CYCLES consecutive cycles, go to RUN.
  - RUN:
    - sys_rst_o=0, locked_o=1.
    - On lock_s=0: go to PRST next cycle and clear retry_cnt. sys_rst_o rises the same edge the state changes.
  - FAIL:
    - pll_rst_o=1, sys_rst_o=1, fail_o=1.
    - Held until rst or restart_i.
- restart_i in any state: next state is PRST, retry_cnt=0, fail_o clears.
- Priority on the same cycle: rst > restart_i > lock loss > timeout/filter completion.
- Release latency with a clean lock: a lock asserted during PRST is ignored until WAIT. From the first WAIT cycle with lock_s=1, sys_rst_o falls 1 + FILT_CYCLES cycles later.
- Glitch rule: any single low cycle of lock_s during FILT restarts filtering. Release never occurs on an unstable lock.
- retry_cnt saturates at MAX_RETRY and never wraps.
- With MAX_RETRY=0, the first timeout goes directly to FAIL.

Optional Feature:
- Macro: PLL_RST_SEQ_LOL_CNT_EN
- Defined:
  - Adds output lol_cnt_o [7:0]. It counts RUN→PRST transitions caused by loss of lock, saturating at 255.
  - Reset to 0 only by rst; unaffected by restart_i.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan (RST_CYCLES=4, FILT_CYCLES=8, TIMEOUT_CYCLES=20, MAX_RETRY=2):
- Nominal lock:
  - Stimulus: release rst; lock rises 3 cycles after pll_rst_o falls and stays high.
  - Required: pll_rst_o high exactly 4 cycles after rst release; sys_rst_o falls 11 cycles after lock rises (2 sync + 1 + 8); locked_o=1; retry_cnt_o=0.
- Timeout retry:
  - Stimulus: lock held low for the first 2 attempts, then raised.
  - Required: pll_rst_o pulses 3 times, each 4 cycles wide, spaced 20 WAIT cycles apart; retry_cnt_o=2; then RUN is reached.
- Fail:
  - Stimulus: lock never asserts.
  - Required: after 3 timeouts fail_o=1, pll_rst_o=1, sys_rst_o=1 and stays there.
  - Then pulse restart_i: fail_o=0, retry_cnt_o=0, and PRST re-runs.
- Filter glitch:
  - Stimulus: lock high 5 cycles, low 1 cycle, high again.
  - Required: sys_rst_o stays high; release occurs 8 full stable cycles after the glitch.
- Loss of lock in RUN:
  - Stimulus: drop lock for 3 cycles.
  - Required: sys_rst_o rises 3 cycles after the lock drop; pll_rst_o pulses for 4 cycles; relock completes.
  - With the macro defined: lol_cnt_o=1.
- Reset mid-sequence:
  - Stimulus: assert rst in FILT cycle 5.
  - Required: the next cycle shows all reset values; the sequence restarts from PRST with the full 4-cycle pulse.
